// File: rtl/pixel_comp_pkg.sv
// Shared constants and the layer-configuration record used by pixel_compositor.
package pixel_comp_pkg;

    localparam int CFG_PHY_W = 14;
    localparam int CFG_SCR_W = 10;

    localparam logic [11:0] KEY_COLOR        = 12'hF0F;
    localparam logic [11:0] BG_COLOR_DEFAULT = 12'h5FF;

    // Field widths track the compositor's default PHY_WIDTH / SCREEN_WIDTH.
    typedef struct packed {
        logic                 en;
        logic [CFG_PHY_W-1:0] x;
        logic [CFG_PHY_W-1:0] y;
        logic [CFG_SCR_W-1:0] w;
        logic [CFG_SCR_W-1:0] h;
    } layer_cfg_t;

endpackage

// File: rtl/layer_hit_test.sv
// Single-layer rectangle hit test and layer-relative coordinates (combinational).
module layer_hit_test #(
    parameter int PHY_WIDTH    = 14,
    parameter int SCREEN_WIDTH = 10
) (
    input  logic                    i_en,
    input  logic [PHY_WIDTH-1:0]    i_lx,
    input  logic [PHY_WIDTH-1:0]    i_ly,
    input  logic [SCREEN_WIDTH-1:0] i_lw,
    input  logic [SCREEN_WIDTH-1:0] i_lh,
    input  logic [SCREEN_WIDTH-1:0] i_px,
    input  logic [SCREEN_WIDTH-1:0] i_py,
    input  logic [PHY_WIDTH-1:0]    i_cam,
    output logic                    o_hit,
    output logic [SCREEN_WIDTH-1:0] o_rel_x,
    output logic [SCREEN_WIDTH-1:0] o_rel_y
);

    localparam int CW = PHY_WIDTH + 1;

    logic [CW-1:0] w_px;
    logic [CW-1:0] w_py;
    logic [CW-1:0] w_lx;
    logic [CW-1:0] w_ly;
    logic [CW-1:0] w_x_end;
    logic [CW-1:0] w_y_end;

    // One extra bit keeps lx+w / ly+h from wrapping back onto low coordinates.
    assign w_px    = CW'(i_px);
    assign w_py    = CW'(i_py) + CW'(i_cam);
    assign w_lx    = CW'(i_lx);
    assign w_ly    = CW'(i_ly);
    assign w_x_end = w_lx + CW'(i_lw);
    assign w_y_end = w_ly + CW'(i_lh);

    assign o_hit = i_en && (w_px >= w_lx) && (w_px < w_x_end)
                        && (w_py >= w_ly) && (w_py < w_y_end);

    assign o_rel_x = i_px - i_lx[SCREEN_WIDTH-1:0];
    assign o_rel_y = w_py[SCREEN_WIDTH-1:0] - i_ly[SCREEN_WIDTH-1:0];

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage sprite compositor with double-buffered layer config and camera offset.
// Define PIXEL_COMPOSITOR_COLORKEY_EN to make KEY_COLOR pixels transparent.
module pixel_compositor
    import pixel_comp_pkg::*;
#(
    parameter int                     LAYER_NUM    = 8,
    parameter int                     PIXEL_WIDTH  = 12,
    parameter int                     SCREEN_WIDTH = CFG_SCR_W,
    parameter int                     PHY_WIDTH    = CFG_PHY_W,
    parameter logic [PIXEL_WIDTH-1:0] BG_COLOR     = BG_COLOR_DEFAULT
) (
    input  logic                                sys_clk,
    input  logic                                sys_rst,
    input  logic                                frame_start,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [$clog2(LAYER_NUM)-1:0]        cfg_layer,
    input  logic                                cfg_en,
    input  logic [PHY_WIDTH-1:0]                cfg_x,
    input  logic [PHY_WIDTH-1:0]                cfg_y,
    input  logic [SCREEN_WIDTH-1:0]             cfg_w,
    input  logic [SCREEN_WIDTH-1:0]             cfg_h,
    input  logic [PHY_WIDTH-1:0]                camera_off,
    input  logic                                pix_valid,
    input  logic                                video_on,
    input  logic [SCREEN_WIDTH-1:0]             x,
    input  logic [SCREEN_WIDTH-1:0]             y,
    output logic [LAYER_NUM*SCREEN_WIDTH-1:0]   layer_x_rom,
    output logic [LAYER_NUM*SCREEN_WIDTH-1:0]   layer_y_rom,
    input  logic [LAYER_NUM*PIXEL_WIDTH-1:0]    layer_rgb,
    output logic [PIXEL_WIDTH-1:0]              rgb,
    output logic                                rgb_valid,
    output logic [$clog2(LAYER_NUM+1)-1:0]      hit_id
);

    localparam int HID_W = $clog2(LAYER_NUM + 1);

    layer_cfg_t r_pend [LAYER_NUM];
    layer_cfg_t r_act  [LAYER_NUM];
    logic [PHY_WIDTH-1:0] r_cam;

    logic                           w_cfg_we;
    layer_cfg_t                     w_cfg_new;
    logic [LAYER_NUM-1:0]           w_hit;
    logic [LAYER_NUM*SCREEN_WIDTH-1:0] w_rel_x;
    logic [LAYER_NUM*SCREEN_WIDTH-1:0] w_rel_y;

    logic                           r_s1_valid;
    logic                           r_s1_von;
    logic [LAYER_NUM-1:0]           r_hit;
    logic [LAYER_NUM*SCREEN_WIDTH-1:0] r_rel_x;
    logic [LAYER_NUM*SCREEN_WIDTH-1:0] r_rel_y;

    logic [LAYER_NUM-1:0]           w_eff_hit;
    logic [HID_W-1:0]               w_hit_id;
    logic [PIXEL_WIDTH-1:0]         w_rgb_sel;

    logic                           r_rgb_valid;
    logic [HID_W-1:0]               r_hit_id;
    logic [PIXEL_WIDTH-1:0]         r_rgb;

    // The bank swap owns the frame_start cycle, so writes are held off then.
    assign cfg_ready = !sys_rst && !frame_start;
    assign w_cfg_we  = cfg_valid && cfg_ready;
    assign w_cfg_new = '{en: cfg_en, x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pend <= '{default: '0};
            r_act  <= '{default: '0};
            r_cam  <= '0;
        end else begin
            for (int i = 0; i < LAYER_NUM; i++) begin
                if (w_cfg_we && int'(cfg_layer) == i) begin
                    r_pend[i] <= w_cfg_new;
                end
            end
            if (frame_start) begin
                r_act <= r_pend;
                r_cam <= camera_off;
            end
        end
    end

    for (genvar g = 0; g < LAYER_NUM; g++) begin : g_layer
        layer_hit_test #(
            .PHY_WIDTH    (PHY_WIDTH),
            .SCREEN_WIDTH (SCREEN_WIDTH)
        ) u_hit (
            .i_en    (r_act[g].en),
            .i_lx    (r_act[g].x),
            .i_ly    (r_act[g].y),
            .i_lw    (r_act[g].w),
            .i_lh    (r_act[g].h),
            .i_px    (x),
            .i_py    (y),
            .i_cam   (r_cam),
            .o_hit   (w_hit[g]),
            .o_rel_x (w_rel_x[g*SCREEN_WIDTH +: SCREEN_WIDTH]),
            .o_rel_y (w_rel_y[g*SCREEN_WIDTH +: SCREEN_WIDTH])
        );
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_von   <= 1'b0;
            r_hit      <= '0;
            r_rel_x    <= '0;
            r_rel_y    <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_von   <= video_on;
            r_hit      <= w_hit;
            r_rel_x    <= w_rel_x;
            r_rel_y    <= w_rel_y;
        end
    end

    // layer_rgb answers the stage-1 coordinates within the following cycle.
    always_comb begin
        w_eff_hit = r_hit;
`ifdef PIXEL_COMPOSITOR_COLORKEY_EN
        for (int i = 0; i < LAYER_NUM; i++) begin
            if (layer_rgb[i*PIXEL_WIDTH +: PIXEL_WIDTH] == KEY_COLOR) begin
                w_eff_hit[i] = 1'b0;
            end
        end
`endif
        w_hit_id  = HID_W'(LAYER_NUM);
        w_rgb_sel = BG_COLOR;
        for (int i = LAYER_NUM - 1; i >= 0; i--) begin
            if (w_eff_hit[i]) begin
                w_hit_id  = HID_W'(i);
                w_rgb_sel = layer_rgb[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rgb_valid <= 1'b0;
            r_hit_id    <= HID_W'(LAYER_NUM);
            r_rgb       <= '0;
        end else begin
            r_rgb_valid <= r_s1_valid;
            r_hit_id    <= w_hit_id;
            r_rgb       <= r_s1_von ? w_rgb_sel : '0;
        end
    end

    assign layer_x_rom = r_rel_x;
    assign layer_y_rom = r_rel_y;
    assign rgb_valid   = r_rgb_valid;
    assign hit_id      = r_hit_id;
    assign rgb         = r_rgb;

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 Parameters SHALL be (name, default, meaning): LAYER_NUM, 8, sprite layers; PIXEL_WIDTH, 12, colour bits; SCREEN_WIDTH, 10, screen coordinate bits; PHY_WIDTH, 14, absolute coordinate bits; BG_COLOR, 12'h5FF, colour where no layer hits.
REQ-002 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-003 sys_rst  in  1  synchronous, active-high reset.
REQ-004 frame_start  in  1  one-cycle pulse at frame start.
REQ-005 cfg_valid/cfg_ready  in/out  1/1  layer-config write handshake.
REQ-006 cfg_layer  in  clog2(LAYER_NUM)  target layer; cfg_en in 1; cfg_x, cfg_y in PHY_WIDTH each; cfg_w, cfg_h in SCREEN_WIDTH each.
REQ-007 camera_off  in  PHY_WIDTH  vertical camera offset, sampled at frame_start.
REQ-008 pix_valid, video_on  in  1 each; x, y  in  SCREEN_WIDTH each: current pixel.
REQ-009 layer_x_rom, layer_y_rom  out  LAYER_NUM*SCREEN_WIDTH each  per-layer relative coordinates.
REQ-010 layer_rgb  in  LAYER_NUM*PIXEL_WIDTH  per-layer colour, returned one cycle after layer_*_rom.
REQ-011 rgb  out  PIXEL_WIDTH; rgb_valid  out  1; hit_id  out  clog2(LAYER_NUM+1) (LAYER_NUM = background).

Function
REQ-012 Config SHALL be double-buffered: a write (cfg_valid && cfg_ready) updates the pending bank; the active bank SHALL take the whole pending bank on the cycle after frame_start.
REQ-013 cfg_ready SHALL be 1 except during the frame_start cycle; a write coinciding with frame_start SHALL be stalled, not lost.
REQ-014 cfg_layer >= LAYER_NUM SHALL be accepted and ignored.
REQ-015 Stage 1 (registered): hit[i] = active_en[i] && x >= lx && x < lx+w && (y+cam) >= ly && (y+cam) < ly+h, using only the active bank and latched camera_off; layer_x_rom[i] = x-lx and layer_y_rom[i] = y+cam-ly, truncated to SCREEN_WIDTH.
REQ-016 Stage 1 comparisons SHALL be computed in PHY_WIDTH+1 bits; an overflowing lx+w or ly+h SHALL NOT wrap into a hit.
REQ-017 Stage 2 (registered): hit_id = lowest-indexed hit layer, else LAYER_NUM; rgb = layer_rgb[hit_id], else BG_COLOR; rgb = 0 when delayed video_on = 0.
REQ-018 Latency from pix_valid to rgb_valid SHALL be exactly 2 cycles; video_on SHALL be delayed alongside; there is no backpressure.
REQ-019 Layers with w = 0 or h = 0 SHALL never hit.

Reset
REQ-020 In reset: both banks cleared (all en = 0); camera latch = 0; rgb = 0, rgb_valid = 0, hit_id = LAYER_NUM, layer_*_rom = 0, cfg_ready = 0.
REQ-021 cfg_ready SHALL rise on the first cycle after reset release; reset mid-frame SHALL flush both pipeline stages with no partial outputs.

Configuration
REQ-022 Macro PIXEL_COMPOSITOR_COLORKEY_EN: when defined, a layer whose layer_rgb equals KEY_COLOR (package constant, 12'hF0F) SHALL be treated as no hit, falling through to the next hit layer or background; when undefined, every hit layer is opaque and KEY_COLOR has no effect.

Structure
REQ-023 Package pixel_comp_pkg SHALL hold KEY_COLOR, BG_COLOR default, and the layer-config record type (en, x, y, w, h).
REQ-024 Sub-module layer_hit_test SHALL hold a single layer's stage-1 compare and relative-coordinate logic and SHALL be instantiated LAYER_NUM times.

Verification
REQ-025 Layer 0 at (100,50) 10x20, en, cam 0, frame_start; pix (105,55) -> 2 cycles later rgb_valid=1, hit_id=0, layer_x_rom[0]=5, layer_y_rom[0]=5.
REQ-026 Layers 1 and 3 overlap at (200,100) -> hit_id=1, rgb=layer_rgb[1]; layer 1 disabled and frame_start issued -> hit_id=3.
REQ-027 Layer 2 reprogrammed mid-frame -> old rectangle used until next frame_start, new one on the cycle after it; write issued on the frame_start cycle sees cfg_ready=0, completes next cycle.
REQ-028 cam=480, layer at y=500 -> screen y=20 hits; lx=16380, w=10 (PHY_WIDTH=14) -> no hit at x=0..3.
REQ-029 COLORKEY_EN defined, layer 0 returns 12'hF0F over layer 4 -> hit_id=4; undefined -> hit_id=0, rgb=12'hF0F.
REQ-030 sys_rst asserted with pipeline full -> next cycle rgb_valid=0, rgb=0, hit_id=LAYER_NUM; all layers disabled after release.
